// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state type, opcode
// constants, the opcode[7:6] operand-length encodings and the reset PC.
package instr_fetch_pkg;

  localparam int unsigned PcWidth = 16;

  typedef enum logic [1:0] {
    StFetch,
    StOper1,
    StOper2,
    StHalt
  } state_e;

  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpHlt = 8'h01;

  // opcode[7:6] length field
  localparam logic [1:0] LenNoneA = 2'b00;
  localparam logic [1:0] LenNoneB = 2'b01;
  localparam logic [1:0] LenOne   = 2'b10;
  localparam logic [1:0] LenTwo   = 2'b11;

  localparam logic [PcWidth-1:0] ResetPc = '0;

  // Operand count (0..2) for an opcode's length field.
  function automatic logic [1:0] num_operands(input logic [1:0] len);
    unique case (len)
      LenOne:  num_operands = 2'd1;
      LenTwo:  num_operands = 2'd2;
      default: num_operands = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: async memory read port, jump/stall control and the outputs
// toward the first pipeline stage.
//   slave  : the fetch unit (reads MEM_DATA/JUMP/JUMP_ADDR/STALL)
//   master : the environment (memory + pipeline control)
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic [7:0]         MEM_DATA;
  logic               JUMP;
  logic [PcWidth-1:0] JUMP_ADDR;
  logic               STALL;
  logic [PcWidth-1:0] MEM_ADDR;
  logic [7:0]         NEXT_INSTR;
  logic [15:0]        CONST_OUT;
  logic               CONST_VALID;
  logic               HALTED;

  modport slave (
    input  MEM_DATA, JUMP, JUMP_ADDR, STALL,
    output MEM_ADDR, NEXT_INSTR, CONST_OUT, CONST_VALID, HALTED
  );

  modport master (
    output MEM_DATA, JUMP, JUMP_ADDR, STALL,
    input  MEM_ADDR, NEXT_INSTR, CONST_OUT, CONST_VALID, HALTED
  );
endinterface

// File: rtl/fetch_pc.sv
// Program counter with load (priority), increment (wraps 0xFFFF->0x0000) and hold.
//   clk_i, rst_ni : clock, async active-low reset (PC -> ResetPc)
//   load_i/load_addr_i : load PC
//   inc_i         : increment PC
//   pc_o          : current PC
module fetch_pc
  import instr_fetch_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [PcWidth-1:0] load_addr_i,
  input  logic               inc_i,
  output logic [PcWidth-1:0] pc_o
);

  logic [PcWidth-1:0] pc_d, pc_q;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + PcWidth'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q <= ResetPc;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads opcode plus 0..2 little-endian operand bytes
// from an async memory and dispatches one opcode per instruction on
// NEXT_INSTR, with its operand word on CONST_OUT and CONST_VALID.
//   CLK, RST_bar : clock, async active-low reset
//   bus          : instr_fetch_if.slave (memory port, JUMP/STALL, outputs)
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_bar,
  instr_fetch_if.slave  bus
);

  state_e             state_d, state_q;
  logic [7:0]         ir_d, ir_q;
  logic [7:0]         lo_d, lo_q;
  logic [7:0]         hi_d, hi_q;
  logic [7:0]         next_instr_d, next_instr_q;
  logic               const_valid_d, const_valid_q;
  logic               pc_load, pc_inc;
  logic [PcWidth-1:0] pc;

  fetch_pc u_fetch_pc (
    .clk_i       (CLK),
    .rst_ni      (RST_bar),
    .load_i      (pc_load),
    .load_addr_i (bus.JUMP_ADDR),
    .inc_i       (pc_inc),
    .pc_o        (pc)
  );

  // HALT beats STALL beats JUMP beats normal fetch; every non-dispatch cycle
  // drives NOP / CONST_VALID=0 by default.
  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    next_instr_d  = OpNop;
    const_valid_d = 1'b0;
    pc_load       = 1'b0;
    pc_inc        = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (!bus.STALL) begin
          if (bus.JUMP) begin
            pc_load = 1'b1;
          end else begin
            ir_d   = bus.MEM_DATA;
            pc_inc = 1'b1;
            if (num_operands(bus.MEM_DATA[7:6]) == 2'd0) begin
              next_instr_d = bus.MEM_DATA;
              if (bus.MEM_DATA == OpHlt) state_d = StHalt;
            end else begin
              state_d = StOper1;
            end
          end
        end
      end
      StOper1: begin
        if (!bus.STALL) begin
          lo_d   = bus.MEM_DATA;
          pc_inc = 1'b1;
          if (num_operands(ir_q[7:6]) == 2'd1) begin
            hi_d          = 8'h00;
            next_instr_d  = ir_q;
            const_valid_d = 1'b1;
            state_d       = StFetch;
          end else begin
            state_d = StOper2;
          end
        end
      end
      StOper2: begin
        if (!bus.STALL) begin
          hi_d          = bus.MEM_DATA;
          pc_inc        = 1'b1;
          next_instr_d  = ir_q;
          const_valid_d = 1'b1;
          state_d       = StFetch;
        end
      end
      StHalt: begin
        // sticky until reset
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_bar) begin
    if (!RST_bar) begin
      state_q       <= StFetch;
      ir_q          <= OpNop;
      lo_q          <= 8'h00;
      hi_q          <= 8'h00;
      next_instr_q  <= OpNop;
      const_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      lo_q          <= lo_d;
      hi_q          <= hi_d;
      next_instr_q  <= next_instr_d;
      const_valid_q <= const_valid_d;
    end
  end

  assign bus.MEM_ADDR    = pc;
  assign bus.NEXT_INSTR  = next_instr_q;
  assign bus.CONST_OUT   = {hi_q, lo_q};
  assign bus.CONST_VALID = const_valid_q;
  assign bus.HALTED      = (state_q == StHalt);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic CLK = 1'b0;
  logic RST_bar = 1'b0;
  always #5 CLK = ~CLK;

  instr_fetch_if bus ();
  logic [7:0] rom [0:65535];
  assign bus.MEM_DATA = rom[bus.MEM_ADDR];

  instr_fetch dut (
    .CLK     (CLK),
    .RST_bar (RST_bar),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          scen;
    bit          stall;
    bit          jump;
    logic [15:0] jaddr;
    logic [7:0]  e_next;
    logic [15:0] e_const;
    bit          e_cv;
    bit          e_halt;
    logic [15:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int s, bit st, bit j, logic [15:0] ja, logic [7:0] n,
                              logic [15:0] c, bit cv, bit h, logic [15:0] a);
    vec_t r;
    r.scen = s; r.stall = st; r.jump = j; r.jaddr = ja;
    r.e_next = n; r.e_const = c; r.e_cv = cv; r.e_halt = h; r.e_addr = a;
    return r;
  endfunction

  // {MEM_ADDR, NEXT_INSTR, CONST_OUT, CONST_VALID, HALTED}
  function automatic logic [41:0] pack(logic [15:0] a, logic [7:0] n, logic [15:0] c,
                                       logic cv, logic h);
    return {a, n, c, cv, h};
  endfunction

  task automatic chk(input string name, input logic [41:0] exp);
    logic [41:0] act;
    act = pack(bus.MEM_ADDR, bus.NEXT_INSTR, bus.CONST_OUT, bus.CONST_VALID, bus.HALTED);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got addr=%h next=%h const=%h cv=%b halt=%b, want addr=%h next=%h const=%h cv=%b halt=%b",
               name, $time, act[41:26], act[25:18], act[17:2], act[1], act[0],
               exp[41:26], exp[25:18], exp[17:2], exp[1], exp[0]);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
  endtask

  task automatic load_rom(input int s);
    clear_rom();
    case (s)
      1: begin rom[0] = 8'h12; rom[1] = 8'h23; rom[2] = 8'h01; end
      2, 6: begin rom[0] = 8'h85; rom[1] = 8'h7A; rom[2] = 8'h01; end
      3, 5: begin rom[0] = 8'hC3; rom[1] = 8'h34; rom[2] = 8'h12; end
      4: begin rom[16'hFFFF] = 8'h20; rom[0] = 8'h01; end
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at a negedge with reset released.
  task automatic do_reset(input string name);
    RST_bar = 1'b0;
    bus.STALL = 1'b0;
    bus.JUMP = 1'b0;
    bus.JUMP_ADDR = 16'h0;
    #1 chk({name, "_rst_async"}, 42'h0);
    @(posedge CLK);
    #1 chk({name, "_rst_hold"}, 42'h0);
    @(negedge CLK);
    RST_bar = 1'b1;
  endtask

  task automatic step(input bit st, input bit j, input logic [15:0] ja);
    bus.STALL = st;
    bus.JUMP = j;
    bus.JUMP_ADDR = ja;
    @(posedge CLK);
    #1;
  endtask

  // Reference model: tracks an instruction as "opcode + operands still owed".
  logic [15:0] m_pc;
  logic [7:0]  m_op, m_lo, m_hi, m_next;
  int          m_need, m_got;
  bit          m_cv, m_halted;

  task automatic model_reset();
    m_pc = 0; m_op = 0; m_lo = 0; m_hi = 0; m_next = 0;
    m_need = 0; m_got = 0; m_cv = 0; m_halted = 0;
  endtask

  task automatic model_edge(input bit st, input bit j, input logic [15:0] ja);
    logic [7:0] d;
    int ops;
    d = rom[m_pc];
    m_next = 8'h00;
    m_cv = 1'b0;
    if (m_halted || st) return;
    if (m_need == 0) begin
      if (j) begin
        m_pc = ja;
        return;
      end
      m_pc = m_pc + 16'd1;
      ops = d[7] ? (d[6] ? 2 : 1) : 0;
      m_op = d;
      if (ops == 0) begin
        m_next = d;
        if (d == 8'h01) m_halted = 1'b1;
      end else begin
        m_need = ops;
        m_got = 0;
      end
    end else begin
      if (m_got == 0) m_lo = d;
      else m_hi = d;
      m_got++;
      m_pc = m_pc + 16'd1;
      if (m_got == m_need) begin
        if (m_need == 1) m_hi = 8'h00;
        m_next = m_op;
        m_cv = 1'b1;
        m_need = 0;
      end
    end
  endtask

  initial begin
    int cur;
    int halt_cnt;
    bit st, j;
    logic [15:0] ja;

    bus.STALL = 1'b0;
    bus.JUMP = 1'b0;
    bus.JUMP_ADDR = 16'h0;
    clear_rom();

    // V1: three 0-operand opcodes ending in HLT; HALT ignores stall/jump
    tbl.push_back(mk(1, 0, 0, 16'h0,    8'h12, 16'h0, 0, 0, 16'h1));
    tbl.push_back(mk(1, 0, 0, 16'h0,    8'h23, 16'h0, 0, 0, 16'h2));
    tbl.push_back(mk(1, 0, 0, 16'h0,    8'h01, 16'h0, 0, 1, 16'h3));
    tbl.push_back(mk(1, 0, 0, 16'h0,    8'h00, 16'h0, 0, 1, 16'h3));
    tbl.push_back(mk(1, 0, 1, 16'h1234, 8'h00, 16'h0, 0, 1, 16'h3));
    tbl.push_back(mk(1, 1, 0, 16'h0,    8'h00, 16'h0, 0, 1, 16'h3));
    // V2: one operand
    tbl.push_back(mk(2, 0, 0, 16'h0, 8'h00, 16'h0000, 0, 0, 16'h1));
    tbl.push_back(mk(2, 0, 0, 16'h0, 8'h85, 16'h007A, 1, 0, 16'h2));
    tbl.push_back(mk(2, 0, 0, 16'h0, 8'h01, 16'h007A, 0, 1, 16'h3));
    // V3: two operands, little-endian
    tbl.push_back(mk(3, 0, 0, 16'h0, 8'h00, 16'h0000, 0, 0, 16'h1));
    tbl.push_back(mk(3, 0, 0, 16'h0, 8'h00, 16'h0034, 0, 0, 16'h2));
    tbl.push_back(mk(3, 0, 0, 16'h0, 8'hC3, 16'h1234, 1, 0, 16'h3));
    tbl.push_back(mk(3, 0, 0, 16'h0, 8'h00, 16'h1234, 0, 0, 16'h4));
    // V4: jump to 0xFFFF, PC wraps to 0x0000
    tbl.push_back(mk(4, 0, 1, 16'hFFFF, 8'h00, 16'h0, 0, 0, 16'hFFFF));
    tbl.push_back(mk(4, 0, 0, 16'h0,    8'h20, 16'h0, 0, 0, 16'h0000));
    tbl.push_back(mk(4, 0, 0, 16'h0,    8'h01, 16'h0, 0, 1, 16'h0001));
    // V5: two-cycle stall in OPER1
    tbl.push_back(mk(5, 0, 0, 16'h0, 8'h00, 16'h0000, 0, 0, 16'h1));
    tbl.push_back(mk(5, 1, 0, 16'h0, 8'h00, 16'h0000, 0, 0, 16'h1));
    tbl.push_back(mk(5, 1, 0, 16'h0, 8'h00, 16'h0000, 0, 0, 16'h1));
    tbl.push_back(mk(5, 0, 0, 16'h0, 8'h00, 16'h0034, 0, 0, 16'h2));
    tbl.push_back(mk(5, 0, 0, 16'h0, 8'hC3, 16'h1234, 1, 0, 16'h3));
    // jump ignored in OPER1, taken in FETCH, stall beats jump
    tbl.push_back(mk(6, 0, 0, 16'h0,    8'h00, 16'h0000, 0, 0, 16'h0001));
    tbl.push_back(mk(6, 0, 1, 16'h4000, 8'h85, 16'h007A, 1, 0, 16'h0002));
    tbl.push_back(mk(6, 0, 1, 16'h4000, 8'h00, 16'h007A, 0, 0, 16'h4000));
    tbl.push_back(mk(6, 1, 1, 16'h0000, 8'h00, 16'h007A, 0, 0, 16'h4000));
    tbl.push_back(mk(6, 0, 0, 16'h0,    8'h00, 16'h007A, 0, 0, 16'h4001));

    @(negedge CLK);
    cur = -1;
    foreach (tbl[i]) begin
      if (tbl[i].scen != cur) begin
        cur = tbl[i].scen;
        load_rom(cur);
        do_reset($sformatf("v%0d", cur));
      end
      step(tbl[i].stall, tbl[i].jump, tbl[i].jaddr);
      chk($sformatf("v%0d_row%0d", tbl[i].scen, i),
          pack(tbl[i].e_addr, tbl[i].e_next, tbl[i].e_const, tbl[i].e_cv, tbl[i].e_halt));
      @(negedge CLK);
    end

    // V6: reset in OPER2 abandons the instruction
    load_rom(3);
    do_reset("v6pre");
    step(0, 0, 16'h0);
    chk("v6_e1", pack(16'h1, 8'h00, 16'h0000, 0, 0));
    @(negedge CLK);
    step(0, 0, 16'h0);
    chk("v6_e2_oper2", pack(16'h2, 8'h00, 16'h0034, 0, 0));
    @(negedge CLK);
    do_reset("v6_mid");
    step(0, 0, 16'h0);
    chk("v6_refetch1", pack(16'h1, 8'h00, 16'h0000, 0, 0));
    @(negedge CLK);
    step(0, 0, 16'h0);
    chk("v6_refetch2", pack(16'h2, 8'h00, 16'h0034, 0, 0));
    @(negedge CLK);
    step(0, 0, 16'h0);
    chk("v6_refetch3", pack(16'h3, 8'hC3, 16'h1234, 1, 0));
    @(negedge CLK);

    // Randomized run against the reference model
    for (int i = 0; i < 65536; i++) begin
      rom[i] = 8'($urandom);
      if (rom[i] == 8'h01 && $urandom_range(0, 9) != 0) rom[i] = 8'h02;
    end
    do_reset("rand");
    model_reset();
    halt_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 199) == 0 || halt_cnt > 4) begin
        do_reset("rand");
        model_reset();
        halt_cnt = 0;
      end
      st = ($urandom_range(0, 3) == 0);
      j = ($urandom_range(0, 7) == 0);
      ja = 16'($urandom);
      model_edge(st, j, ja);
      step(st, j, ja);
      chk("rand", pack(m_pc, m_next, {m_hi, m_lo}, m_cv, m_halted));
      if (m_halted) halt_cnt++;
      @(negedge CLK);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
